// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM-subset control unit.
// Holds FSM states, ALU/condition/opcode encodings and the cmd-to-ALU decode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Unsupported data-processing commands fall back to ADD.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        logic [1:0] ctl;
        case (cmd)
            CMD_ADD: ctl = ALU_ADD;
            CMD_SUB: ctl = ALU_SUB;
            CMD_AND: ctl = ALU_AND;
            CMD_ORR: ctl = ALU_ORR;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// master is the controller side, slave is the datapath/memory side.
interface mc_controller_if;
    import mc_ctrl_pkg::*;

    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         MemReady;

    logic         PCWrite;
    logic         AdrSrc;
    logic         IRWrite;
    logic         MemWrite;
    logic         RegWrite;
    logic         ALUSrcA;
    logic         ByteMem;
    logic [1:0]   ResultSrc;
    logic [1:0]   ALUSrcB;
    logic [1:0]   ImmSrc;
    logic [1:0]   RegSrc;
    logic [1:0]   ALUControl;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA, ByteMem,
        output ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA, ByteMem,
        input  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

endinterface

// File: rtl/mc_condcheck.sv
// ARM condition-code evaluation: Cond field against the NZCV flag register.
module mc_condcheck
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ok
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign {n_s, z_s, c_s, v_s} = flags;

    // Full condition table; the 1111 encoding never executes.
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = z_s;
            COND_NE: cond_ok = ~z_s;
            COND_CS: cond_ok = c_s;
            COND_CC: cond_ok = ~c_s;
            COND_MI: cond_ok = n_s;
            COND_PL: cond_ok = ~n_s;
            COND_VS: cond_ok = v_s;
            COND_VC: cond_ok = ~v_s;
            COND_HI: cond_ok = c_s & ~z_s;
            COND_LS: cond_ok = ~c_s | z_s;
            COND_GE: cond_ok = (n_s == v_s);
            COND_LT: cond_ok = (n_s != v_s);
            COND_GT: cond_ok = ~z_s & (n_s == v_s);
            COND_LE: cond_ok = z_s | (n_s != v_s);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore control unit: sequences each instruction, drives datapath
// enables/selects, owns the NZCV register and conditional-execution gating.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter bit         MEM_HANDSHAKE = 1'b0,
    parameter logic [3:0] FLAGS_RST     = 4'b0000
) (
    input  logic               clk,
    input  logic               reset,
    mc_controller_if.master    bus
);

    state_t     state_r;
    state_t     next_s;
    logic [3:0] flags_r;
    logic       cond_q_r;

    logic [1:0] op_s;
    logic [5:0] funct_s;
    logic [3:0] rd_s;
    logic [3:0] cond_s;
    logic [1:0] alu_dp_s;
    logic       cond_ok_s;
    logic       ready_s;
    logic       flag_we_s;
    logic       cv_we_s;
    logic       unused_rn_s;

    logic       pc_write_s;
    logic       adr_src_s;
    logic       ir_write_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_control_s;

    assign cond_s      = bus.Instr[31:28];
    assign op_s        = bus.Instr[27:26];
    assign funct_s     = bus.Instr[25:20];
    assign rd_s        = bus.Instr[15:12];
    assign alu_dp_s    = alu_decode(bus.Instr[24:21]);
    assign unused_rn_s = ^bus.Instr[19:16];

    assign ready_s = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

    mc_condcheck u_condcheck (
        .cond    (cond_s),
        .flags   (flags_r),
        .cond_ok (cond_ok_s)
    );

    // Flags commit on the edge leaving EXECR/EXECI; C/V only for arithmetic ops.
    assign flag_we_s = ((state_r == EXECR) || (state_r == EXECI)) && cond_q_r && funct_s[0];
    assign cv_we_s   = (alu_dp_s == ALU_ADD) || (alu_dp_s == ALU_SUB);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // NZCV register and the condition result captured at the end of DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r  <= FLAGS_RST;
            cond_q_r <= 1'b0;
        end else begin
            if (state_r == DECODE) begin
                cond_q_r <= cond_ok_s;
            end
            if (flag_we_s) begin
                flags_r[3:2] <= bus.ALUFlags[3:2];
                if (cv_we_s) begin
                    flags_r[1:0] <= bus.ALUFlags[1:0];
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = FETCH;
        case (state_r)
            FETCH: begin
                if (ready_s) next_s = DECODE;
                else         next_s = FETCH;
            end
            DECODE: begin
                if (!cond_ok_s) begin
                    next_s = FETCH;
                end else begin
                    case (op_s)
                        OP_DP:   next_s = funct_s[5] ? EXECI : EXECR;
                        OP_MEM:  next_s = MEMADR;
                        OP_BR:   next_s = BRANCH;
                        default: next_s = FETCH;
                    endcase
                end
            end
            MEMADR:   next_s = funct_s[0] ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (ready_s) next_s = MEMWB;
                else         next_s = MEMREAD;
            end
            MEMWB:    next_s = FETCH;
            MEMWRITE: begin
                if (ready_s) next_s = FETCH;
                else         next_s = MEMWRITE;
            end
            EXECR:    next_s = ALUWB;
            EXECI:    next_s = ALUWB;
            ALUWB:    next_s = FETCH;
            BRANCH:   next_s = FETCH;
            default:  next_s = FETCH;
        endcase
    end

    // Moore output decode; architectural writes after DECODE are gated by cond_q.
    always_comb begin
        pc_write_s    = 1'b0;
        adr_src_s     = 1'b0;
        ir_write_s    = 1'b0;
        mem_write_s   = 1'b0;
        reg_write_s   = 1'b0;
        alu_src_a_s   = 1'b0;
        result_src_s  = 2'b00;
        alu_src_b_s   = 2'b00;
        alu_control_s = ALU_ADD;
        case (state_r)
            FETCH: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = ready_s;
                pc_write_s   = ready_s;
            end
            DECODE: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
            end
            MEMADR: begin
                alu_src_b_s   = 2'b01;
                alu_control_s = bus.Instr[23] ? ALU_ADD : ALU_SUB;
            end
            MEMREAD: begin
                adr_src_s = 1'b1;
            end
            MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = cond_q_r;
            end
            MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = cond_q_r;
            end
            EXECR: begin
                alu_control_s = alu_dp_s;
            end
            EXECI: begin
                alu_src_b_s   = 2'b01;
                alu_control_s = alu_dp_s;
            end
            ALUWB: begin
                reg_write_s = cond_q_r;
                pc_write_s  = cond_q_r & (rd_s == 4'd15);
            end
            BRANCH: begin
                alu_src_b_s  = 2'b01;
                result_src_s = 2'b10;
                pc_write_s   = cond_q_r;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    assign bus.PCWrite    = pc_write_s  & ~reset;
    assign bus.IRWrite    = ir_write_s  & ~reset;
    assign bus.MemWrite   = mem_write_s & ~reset;
    assign bus.RegWrite   = reg_write_s & ~reset;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ALUControl = alu_control_s;

    assign bus.ImmSrc     = op_s;
    assign bus.RegSrc     = {(op_s == OP_MEM) & ~funct_s[0], (op_s == OP_BR)};
    assign bus.ByteMem    = (op_s == OP_MEM) & funct_s[2];

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the ARM-subset datapath: the successor to the single-cycle decoder/condition-logic pair. It sequences each instruction through a Moore state machine and generates all datapath enables and mux selects. It holds the NZCV flag register and evaluates conditional execution. It adds byte/word memory selection, up/down address offset, early retirement of condition-failed instructions, and an optional memory-ready handshake. It sits between the instruction register (IR) output and a shared-memory multicycle datapath.

## Interface
- MEM_HANDSHAKE, 0: 1 = FETCH, MEMREAD and MEMWRITE wait for MemReady; 0 = memory is treated as always ready.
- FLAGS_RST, 4'b0000: reset value of the NZCV register.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  [31:12]  IR contents; stable from DECODE onward.
- ALUFlags  in  [3:0]  NZCV from the ALU, in the current cycle.
- MemReady  in  1  memory access complete; ignored when MEM_HANDSHAKE=0.
- PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA, ByteMem  out  1  datapath enables and selects.
- ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl  out  [1:0]  datapath selects.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- Decode fields:
  - Op = Instr[27:26]; Funct = Instr[25:20]; Rd = Instr[15:12]; Cond = Instr[31:28].
- DECODE transitions:
  - cond_ok=0 → FETCH.
  - Op=00 → EXECI if Funct[5], else EXECR.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 → FETCH (undefined instruction treated as a NOP).
- Other transitions:
  - MEMADR → MEMREAD if Funct[0] (L), else MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECR/EXECI → ALUWB → FETCH.
  - BRANCH → FETCH.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01; ALUControl=ADD if Instr[23] (U), else SUB.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcB=00. EXECI: ALUSrcB=01. Both: ALUSrcA=0, ALUControl decoded from cmd.
  - ALUWB: ResultSrc=00, RegWrite=1; PCWrite=1 when Rd=15.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=1.
- cmd decode (Instr[24:21]) to ALUControl:
  - 0100 → ADD=00; 0010 → SUB=01; 0000 → AND=10; 1100 → ORR=11; any other value → ADD.
- Combinational fields, valid in every state:
  - ImmSrc=Op.
  - RegSrc[0]=(Op==10).
  - RegSrc[1]=(Op==01 & ~Funct[0]).
  - ByteMem=(Op==01 & Funct[2]).
- Condition logic:
  - cond_ok is computed from Cond and the flag register using the full ARM condition table (EQ..AL; 1111 = never).
  - cond_ok is registered into cond_q at the end of DECODE.
- Write gating: RegWrite and MemWrite after DECODE, and PCWrite in ALUWB and BRANCH, are ANDed with cond_q.
- Flag update at the end of EXECR/EXECI, only when cond_q=1 and Funct[0] (S)=1:
  - N and Z are always written.
  - C and V are written only for ADD/SUB.

## Timing
- Reset: state=FETCH, flags=FLAGS_RST, cond_q=0.
- While reset=1: PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
- Latency (MEM_HANDSHAKE=0):
  - branch = 3 cycles.
  - data-processing = 4 cycles.
  - STR = 4 cycles.
  - LDR = 5 cycles.
  - condition-failed = 2 cycles.
- MEM_HANDSHAKE=1:
  - FETCH holds while MemReady=0; IRWrite and PCWrite assert only in the cycle MemReady=1.
  - MEMREAD holds while MemReady=0.
  - MEMWRITE keeps MemWrite high until the cycle MemReady=1, then exits.
- Flags change only on the clock edge that ends EXECR/EXECI. ALUWB of the same instruction sees the updated flags, but write gating uses cond_q, not the updated flags.
- Mid-instruction reset returns to FETCH on the next edge. No partial write is issued in the reset cycle.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum type;
  - ALU control localparams ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR;
  - the 4-bit condition codes;
  - opcode constants OP_DP, OP_MEM, OP_BR.
- One sub-module, mc_condcheck: combinational Cond × NZCV → cond_ok.
- FSM, output decode and flag register stay in mc_controller.

## Test plan
- ADD R1,R2,R3 (0xE0821003), flags Z=0 → states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4; ALUControl=00.
- LDRB R4,[R0,#8] (0xE5D04008) → 5 cycles; ByteMem=1; MEMADR ALUControl=00; RegWrite only in MEMWB with ResultSrc=01.
- STR R4,[R0,#-8] (0xE5004008), MEM_HANDSHAKE=1, MemReady low for 3 cycles in MEMWRITE → MemWrite high for 4 cycles, ALUControl=01 in MEMADR, RegSrc=10.
- ADDEQ R1,R2,R3 (0x00821003) with Z=0 → DECODE→FETCH; no RegWrite; 2 cycles total.
- SUBS R1,R1,R1 (0xE0511001) → ALUFlags 4'b0110 latched at end of EXECR; then BEQ (0x0A000001) → PCWrite=1 in BRANCH.
- Reset asserted during MEMWRITE → MemWrite=0 in that cycle; next state FETCH; flags restored to FLAGS_RST.
